// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the UART receive path: parity codes, FSM states,
// FIFO entry layout and the fractional baud increment.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } rx_entry_t;

   // round(baud * os * 2^acc_w / clock_hz)
   function automatic logic [63:0] calc_inc(input logic [63:0] clock_hz,
                                            input logic [63:0] baud,
                                            input logic [63:0] os,
                                            input int unsigned acc_w);
      logic [63:0] num;
      num = (baud * os) << acc_w;
      return (num + (clock_hz >> 1)) / clock_hz;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
// Fractional-N oversample tick generator: a phase accumulator whose carry is the
// tick, so the long-run tick rate is exact to within 2^-ACC_W.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK      = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned ACC_W      = 24
) (
   input  logic clock,
   input  logic reset,
   output logic tick_o
);

   localparam logic [63:0] INC = calc_inc(64'(CLOCK), 64'(BAUD), 64'(OVERSAMPLE), ACC_W);

   if (INC >= (64'd1 << ACC_W)) begin : g_inc_range
      $fatal(1, "uart_baud_gen: baud increment does not fit the accumulator");
   end

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic             carry_c;

   always_comb begin
      {carry_c, acc_d} = {1'b0, acc_q} + (ACC_W+1)'(INC);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q  <= '0;
         tick_o <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_o <= carry_c;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// UART receiver with configurable frame format, majority-vote bit sampling,
// break detection and a first-word-fall-through receive FIFO with error tags.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK      = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ACC_W      = 24
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          readdata,
   input  logic                          clearerr,
   output logic [7:0]                    data,
   output logic                          dataready,
   output logic                          parity_err,
   output logic                          framing,
   output logic                          overrun,
   output logic                          break_det,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
   localparam int unsigned SMP_A = OVERSAMPLE/2 - 2;
   localparam int unsigned SMP_B = OVERSAMPLE/2 - 1;
   localparam int unsigned SMP_C = OVERSAMPLE/2;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);

   if ((OVERSAMPLE != 8 && OVERSAMPLE != 16) || DATA_BITS < 5 || DATA_BITS > 8 ||
       (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) ||
       (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $fatal(1, "uart_rx_fifo: unsupported parameter set");
   end

   logic baud_tick;

   uart_baud_gen #(
      .CLOCK      (CLOCK),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE),
      .ACC_W      (ACC_W)
   ) u_baud_gen (
      .clock  (clock),
      .reset  (reset),
      .tick_o (baud_tick)
   );

   // Two-stage synchroniser plus one history stage for falling-edge detection.
   logic rx_meta_q, rx_sync_q, rx_prev_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   rx_state_e            state_q, state_d;
   logic [PH_W-1:0]      ph_q, ph_d;
   logic [3:0]           bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [1:0]           smp_q, smp_d;
   logic                 any_hi_q, any_hi_d;
   logic                 perr_q, perr_d;
   logic                 push_q, push_d;
   logic                 brk_set_q, brk_set_d;
   rx_entry_t            entry_q, entry_d;

   logic fall_c, in_win_c, decide_c, bit_end_c, bit_c, brk_c, exp_par_c;

   always_comb begin
      fall_c    = rx_prev_q & ~rx_sync_q;
      in_win_c  = baud_tick & ((ph_q == PH_W'(SMP_A)) | (ph_q == PH_W'(SMP_B)) |
                               (ph_q == PH_W'(SMP_C)));
      decide_c  = baud_tick & (ph_q == PH_W'(SMP_C));
      bit_end_c = baud_tick & (ph_q == PH_W'(OVERSAMPLE - 1));
      bit_c     = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_sync_q) | (smp_q[0] & rx_sync_q);
      brk_c     = ~any_hi_q & ~rx_sync_q;
      exp_par_c = (PARITY == PAR_ODD) ? ~(^shreg_q) : ^shreg_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         ph_q      <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         smp_q     <= '0;
         any_hi_q  <= 1'b0;
         perr_q    <= 1'b0;
         push_q    <= 1'b0;
         brk_set_q <= 1'b0;
         entry_q   <= '0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         smp_q     <= smp_d;
         any_hi_q  <= any_hi_d;
         perr_q    <= perr_d;
         push_q    <= push_d;
         brk_set_q <= brk_set_d;
         entry_q   <= entry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (fall_c) state_d = ST_START;
         ST_START: begin
            if (decide_c && bit_c)  state_d = ST_IDLE;
            else if (bit_end_c)     state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end_c && bitcnt_q == 4'(DATA_BITS))
               state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: if (bit_end_c) state_d = ST_STOP;
         ST_STOP:   if (decide_c) state_d = brk_c ? ST_BREAK : ST_IDLE;
         ST_BREAK:  if (bit_end_c && rx_sync_q) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Sampling datapath; a frame is handed to the FIFO one cycle after its stop decision.
   always_comb begin
      ph_d      = ph_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      smp_d     = smp_q;
      any_hi_d  = any_hi_q;
      perr_d    = perr_q;
      push_d    = 1'b0;
      brk_set_d = 1'b0;
      entry_d   = entry_q;
      if (baud_tick) ph_d = ph_q + PH_W'(1);
      if (in_win_c)  smp_d = {smp_q[0], rx_sync_q};
      case (state_q)
         ST_IDLE: begin
            ph_d     = '0;
            bitcnt_d = '0;
            any_hi_d = 1'b0;
            perr_d   = 1'b0;
         end
         ST_DATA: begin
            if (in_win_c) any_hi_d = any_hi_q | rx_sync_q;
            if (decide_c) begin
               shreg_d  = {bit_c, shreg_q[DATA_BITS-1:1]};
               bitcnt_d = bitcnt_q + 4'd1;
            end
         end
         ST_PARITY: begin
            if (in_win_c) any_hi_d = any_hi_q | rx_sync_q;
            if (decide_c) perr_d = bit_c ^ exp_par_c;
         end
         ST_STOP: begin
            if (decide_c) begin
               push_d        = 1'b1;
               brk_set_d     = brk_c;
               entry_d.data  = 8'(shreg_q);
               entry_d.perr  = perr_q;
               entry_d.ferr  = ~bit_c;
               if (brk_c) ph_d = '0;
            end
         end
         ST_BREAK: begin
            if (!rx_sync_q) ph_d = '0;
         end
         default: ;
      endcase
   end

   // Receive FIFO with wrap-bit pointers; head outputs are registered from next-state values.
   rx_entry_t       mem_q [FIFO_DEPTH];
   rx_entry_t       head_c;
   logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d, cnt_c, cnt_d;
   logic            empty_c, full_c, pop_c, wr_c, ovr_c;

   always_comb begin
      cnt_c   = wptr_q - rptr_q;
      empty_c = (cnt_c == '0);
      full_c  = (cnt_c == (AW+1)'(FIFO_DEPTH));
      pop_c   = readdata & ~empty_c;
      wr_c    = push_q & (~full_c | pop_c);
      ovr_c   = push_q & full_c & ~pop_c;
      rptr_d  = rptr_q + (AW+1)'(pop_c);
      wptr_d  = wptr_q + (AW+1)'(wr_c);
      cnt_d   = wptr_d - rptr_d;
      head_c  = '0;
      if (cnt_d != '0) begin
         if (wr_c && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) head_c = entry_q;
         else                                             head_c = mem_q[rptr_d[AW-1:0]];
      end
   end

   always_ff @(posedge clock) begin
      if (wr_c) mem_q[wptr_q[AW-1:0]] <= entry_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count      <= '0;
         dataready  <= 1'b0;
         data       <= '0;
         parity_err <= 1'b0;
         framing    <= 1'b0;
         overrun    <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count      <= cnt_d;
         dataready  <= (cnt_d != '0);
         data       <= head_c.data;
         parity_err <= head_c.perr;
         framing    <= head_c.ferr;
         overrun    <= ovr_c | (overrun & ~clearerr);
         break_det  <= brk_set_q | (break_det & ~clearerr);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_rx_fifo: directed frames on a default instance and randomized
// frames on a 7E2, depth-4 instance, checked against a queue reference model.
module tb_uart_rx_fifo;

   localparam real BIT_A = 1.0e9 / 115200.0;
   localparam real BIT_B = 1000.0;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx_a, rd_a, clr_a, rx_b, rd_b, clr_b;
   logic [7:0] data_a, data_b;
   logic       rdy_a, pe_a, fe_a, ov_a, bk_a;
   logic       rdy_b, pe_b, fe_b, ov_b, bk_b;
   logic [3:0] cnt_a;
   logic [2:0] cnt_b;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t q[$];
   exp_t e;
   logic [7:0] d;
   logic       pbit, stop_ok, brk, m_ov, m_bk;
   int         n_pop;

   always #10 clock = ~clock;

   uart_rx_fifo u_a (
      .clock (clock), .reset (reset), .rx (rx_a), .readdata (rd_a), .clearerr (clr_a),
      .data (data_a), .dataready (rdy_a), .parity_err (pe_a), .framing (fe_a),
      .overrun (ov_a), .break_det (bk_a), .count (cnt_a)
   );

   uart_rx_fifo #(
      .BAUD (1_000_000), .OVERSAMPLE (8), .DATA_BITS (7), .PARITY (1),
      .STOP_BITS (2), .FIFO_DEPTH (4)
   ) u_b (
      .clock (clock), .reset (reset), .rx (rx_b), .readdata (rd_b), .clearerr (clr_b),
      .data (data_b), .dataready (rdy_b), .parity_err (pe_b), .framing (fe_b),
      .overrun (ov_b), .break_det (bk_b), .count (cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx_a = v;
      else            rx_b = v;
   endtask

   // Start bit, data LSB first, optional parity, stop bits, one idle bit.
   task automatic send_frame(input int which, input logic [7:0] dv, input int nbits,
                             input bit par_en, input logic pb, input logic stop_v,
                             input int nstop, input real bitns, input int gbit);
      set_rx(which, 1'b0);
      #(bitns);
      for (int i = 0; i < nbits; i++) begin
         set_rx(which, dv[i]);
         if (i == gbit) begin
            #5000;
            set_rx(which, 1'b0);
            #1000;
            set_rx(which, dv[i]);
            #(bitns - 6000.0);
         end else begin
            #(bitns);
         end
      end
      if (par_en) begin
         set_rx(which, pb);
         #(bitns);
      end
      set_rx(which, stop_v);
      #(bitns);
      for (int i = 1; i < nstop; i++) begin
         set_rx(which, 1'b1);
         #(bitns);
      end
      set_rx(which, 1'b1);
      #(bitns);
      @(negedge clock);
   endtask

   task automatic pop(input int which);
      @(negedge clock);
      if (which == 0) rd_a = 1'b1; else rd_b = 1'b1;
      @(negedge clock);
      rd_a = 1'b0;
      rd_b = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic pulse_clr(input int which);
      @(negedge clock);
      if (which == 0) clr_a = 1'b1; else clr_b = 1'b1;
      @(negedge clock);
      clr_a = 1'b0;
      clr_b = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      reset = 1'b0;
      rx_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
      rx_b = 1'b1; rd_b = 1'b0; clr_b = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_a_data",  32'(data_a), 32'h0);
      check("rst_a_rdy",   32'(rdy_a),  32'h0);
      check("rst_a_cnt",   32'(cnt_a),  32'h0);
      check("rst_a_flags", 32'({pe_a, fe_a, ov_a, bk_a}), 32'h0);
      check("rst_b_cnt",   32'(cnt_b),  32'h0);
      check("rst_b_flags", 32'({rdy_b, pe_b, fe_b, ov_b, bk_b}), 32'h0);
      reset = 1'b1;
      repeat (20) @(negedge clock);

      // Default 8N1 frame and pop
      send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b1, 1, BIT_A, -1);
      check("a55_data", 32'(data_a), 32'h55);
      check("a55_rdy",  32'(rdy_a),  32'h1);
      check("a55_fe",   32'(fe_a),   32'h0);
      check("a55_pe",   32'(pe_a),   32'h0);
      check("a55_cnt",  32'(cnt_a),  32'h1);
      pop(0);
      check("a55_pop_cnt", 32'(cnt_a), 32'h0);
      check("a55_pop_rdy", 32'(rdy_a), 32'h0);

      // Short low glitch late in data bit 4 must be voted out
      send_frame(0, 8'h39, 8, 1'b0, 1'b0, 1'b1, 1, BIT_A, 4);
      check("glitch_data",  32'(data_a), 32'h39);
      check("glitch_flags", 32'({pe_a, fe_a, ov_a, bk_a}), 32'h0);
      check("glitch_cnt",   32'(cnt_a),  32'h1);
      pop(0);

      // False start followed by a clean frame
      set_rx(0, 1'b0);
      #3500;
      set_rx(0, 1'b1);
      #(3.0 * BIT_A);
      send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b1, 1, BIT_A, -1);
      check("fstart_cnt",  32'(cnt_a),  32'h1);
      check("fstart_data", 32'(data_a), 32'h55);
      pop(0);
      check("fstart_empty", 32'(cnt_a), 32'h0);

      // Break: 30 bit times low
      set_rx(0, 1'b0);
      #(30.0 * BIT_A);
      @(negedge clock);
      check("brk_cnt",  32'(cnt_a),  32'h1);
      check("brk_data", 32'(data_a), 32'h0);
      check("brk_fe",   32'(fe_a),   32'h1);
      check("brk_det",  32'(bk_a),   32'h1);
      set_rx(0, 1'b1);
      #(2.0 * BIT_A);
      @(negedge clock);
      check("brk_single", 32'(cnt_a), 32'h1);
      send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1, 1, BIT_A, -1);
      check("brk_next_cnt", 32'(cnt_a), 32'h2);
      check("brk_head_fe",  32'(fe_a),  32'h1);
      pulse_clr(0);
      check("clr_bk",      32'(bk_a),  32'h0);
      check("clr_keep_fe", 32'(fe_a),  32'h1);
      check("clr_keep_cnt", 32'(cnt_a), 32'h2);

      // Asynchronous reset in the middle of a frame
      set_rx(0, 1'b0);
      #(BIT_A);
      set_rx(0, 1'b1);
      #(1.3 * BIT_A);
      reset = 1'b0;
      #1;
      check("mid_rst_cnt",   32'(cnt_a),  32'h0);
      check("mid_rst_rdy",   32'(rdy_a),  32'h0);
      check("mid_rst_data",  32'(data_a), 32'h0);
      check("mid_rst_flags", 32'({pe_a, fe_a, ov_a, bk_a}), 32'h0);
      #100;
      reset = 1'b1;
      #(2.0 * BIT_A);
      send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1, BIT_A, -1);
      check("post_rst_data", 32'(data_a), 32'hA5);
      check("post_rst_cnt",  32'(cnt_a),  32'h1);
      check("post_rst_fe",   32'(fe_a),   32'h0);
      pop(0);

      // Even parity on the 7E2 instance: 0x07 has three ones
      send_frame(1, 8'h07, 7, 1'b1, 1'b0, 1'b1, 2, BIT_B, -1);
      check("par_bad_pe",   32'(pe_b),   32'h1);
      check("par_bad_data", 32'(data_b), 32'h07);
      check("par_bad_fe",   32'(fe_b),   32'h0);
      pop(1);
      send_frame(1, 8'h07, 7, 1'b1, 1'b1, 1'b1, 2, BIT_B, -1);
      check("par_ok_pe",   32'(pe_b),   32'h0);
      check("par_ok_data", 32'(data_b), 32'h07);
      pop(1);

      // Overflow of the depth-4 FIFO
      for (int k = 0; k < 5; k++) begin
         d = 8'h10 + 8'(k);
         send_frame(1, d, 7, 1'b1, ^d, 1'b1, 2, BIT_B, -1);
      end
      check("ovf_flag", 32'(ov_b),  32'h1);
      check("ovf_cnt",  32'(cnt_b), 32'h4);
      for (int k = 0; k < 4; k++) begin
         check("ovf_pop_data", 32'(data_b), 32'h10 + 32'(k));
         check("ovf_pop_pe",   32'(pe_b),   32'h0);
         pop(1);
      end
      check("ovf_empty", 32'(cnt_b), 32'h0);
      pulse_clr(1);
      check("ovf_clr", 32'(ov_b), 32'h0);

      // Randomized frames against the queue model
      m_ov = 1'b0;
      m_bk = 1'b0;
      for (int it = 0; it < 16; it++) begin
         d       = 8'($urandom_range(0, 127));
         pbit    = ($urandom_range(0, 3) != 0) ? ^d : ~(^d);
         stop_ok = ($urandom_range(0, 4) != 0);
         send_frame(1, d, 7, 1'b1, pbit, stop_ok, 2, BIT_B, -1);
         e.data = d;
         e.perr = (pbit != ^d);
         e.ferr = ~stop_ok;
         brk    = ~stop_ok && (d == 8'h00) && !pbit;
         if (q.size() == 4) m_ov = 1'b1;
         else               q.push_back(e);
         if (brk) m_bk = 1'b1;
         n_pop = $urandom_range(0, 2);
         for (int j = 0; j < n_pop; j++) begin
            if (q.size() > 0) begin
               check("rnd_data", 32'(data_b), 32'(q[0].data));
               check("rnd_pe",   32'(pe_b),   32'(q[0].perr));
               check("rnd_fe",   32'(fe_b),   32'(q[0].ferr));
               pop(1);
               void'(q.pop_front());
            end
         end
         check("rnd_cnt", 32'(cnt_b), 32'(q.size()));
         check("rnd_rdy", 32'(rdy_b), 32'(q.size() != 0));
         check("rnd_ov",  32'(ov_b),  32'(m_ov));
         check("rnd_bk",  32'(bk_b),  32'(m_bk));
         if ($urandom_range(0, 3) == 0) begin
            pulse_clr(1);
            m_ov = 1'b0;
            m_bk = 1'b0;
            check("rnd_clr", 32'({ov_b, bk_b}), 32'h0);
         end
      end
      while (q.size() > 0) begin
         check("drain_data", 32'(data_b), 32'(q[0].data));
         check("drain_tags", 32'({pe_b, fe_b}), 32'({q[0].perr, q[0].ferr}));
         pop(1);
         void'(q.pop_front());
      end
      check("drain_cnt", 32'(cnt_b), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the single-buffer UART receiver: configurable frame format (5–8 data bits, optional parity, 1 or 2 stop bits), plus a fractional-N baud generator that removes divider slide error. Received characters go into a first-word-fall-through receive FIFO, with per-character error tags. Sits between the async rx pin and a CPU/bus register interface.

Parameters:
CLOCK, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in baud
OVERSAMPLE, 16, samples per bit; allowed values 8 or 16
DATA_BITS, 8, data bits per frame, 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2; only the first stop bit is checked
FIFO_DEPTH, 8, receive FIFO entries; power of 2, at least 2
ACC_W, 24, width of the fractional baud accumulator

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx  in  1  serial input, asynchronous to clock, idles high
readdata  in  1  one-cycle pop strobe for the FIFO head
clearerr  in  1  one-cycle strobe that clears the sticky flags
data  out  8  FIFO head data, LSB-aligned, upper bits 0 when DATA_BITS<8
dataready  out  1  FIFO not empty
parity_err  out  1  parity error tag of the head entry; 0 when PARITY=0
framing  out  1  framing error tag of the head entry
overrun  out  1  sticky: a character was dropped because the FIFO was full
break_det  out  1  sticky: break condition detected
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, count=0, data=0, dataready=0, all flags 0, state IDLE, accumulator 0. Synchroniser stages reset to 1.
- rx passes through a 2-FF synchroniser before any use.
- Baud tick: each clock, acc <= acc + INC. tick is the carry out. INC = round(BAUD*OVERSAMPLE*2^ACC_W/CLOCK) is a localparam (618475 at the defaults). Elaboration fails if INC >= 2^ACC_W.
- Bit value = majority of samples OVERSAMPLE/2-1, /2, /2+1 within the bit (samples 7, 8, 9 at 16x).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START on a synchronised falling edge. The tick phase counter restarts at 0.
  - START: a majority-high start bit is a false start -> IDLE, no FIFO write.
  - DATA: shift in bits LSB first, DATA_BITS of them -> PARITY if PARITY!=0, else STOP.
  - PARITY: compare the sampled bit against the parity of the data bits (even or odd).
  - STOP: decide at the centre sample; do not wait for the bit end. Then write {data, perr, ferr} to the FIFO and go to IDLE, re-arming for the next start edge. The second stop bit is not sampled.
  - ferr=1 when the stop bit is majority-low.
  - If ferr=1 and every data, parity and stop sample was 0: set break_det, push one entry (data 0, ferr=1), go to BREAK. BREAK -> IDLE after rx is high for one full bit time.
- Write latency: the entry is visible (dataready=1, data valid) on the 2nd clock after the tick that produced the stop-bit centre sample.
- Pop: readdata with dataready=1 advances the head on the next edge. readdata when empty is ignored.
- Full FIFO on write: the new character is discarded, overrun=1, and existing entries are untouched.
- Simultaneous pop and write when full: the pop takes effect first, the write is accepted, overrun is not set.
- Simultaneous clearerr and a new error event: the set wins.
- clearerr clears overrun and break_det only. Per-entry tags leave with their entry.
- count wraps never. Pointers are $clog2(FIFO_DEPTH) bits with an extra wrap bit for full/empty.

Decomposition:
- Package uart_pkg: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), the FSM state enum, and a function computing INC.
- Sub-module uart_baud_gen (fractional accumulator, tick out) so the TX side can reuse it.
- The FIFO stays inline.

Test Plan:
- Defaults, frame 0x55 with 8680.6 ns bits -> data=0x55, dataready=1, framing=0, parity_err=0, count=1. readdata pulse -> count=0, dataready=0.
- 0x39 with a 1 µs low glitch starting 5 µs into bit 4 -> data=0x39, no error flags.
- Low pulse of 3.5 µs on an idle line (false start), then 0x55 -> exactly one entry, 0x55.
- PARITY=1, send 0x07 with parity bit 0 -> parity_err=1, data=0x07. Same frame with parity bit 1 -> parity_err=0.
- FIFO_DEPTH=4, send 0x10..0x14 without reading -> overrun=1, count=4, pops return 0x10..0x13. clearerr -> overrun=0.
- rx low for 30 bit times -> one entry (data 0x00, framing=1), break_det=1, no further entries until rx returns high. reset pulled low mid-frame -> all outputs at reset values immediately, and the next clean 0xA5 is received correctly.
